// File: rtl/qpll_supervisor.sv
// qpll_supervisor
// Power-up / reset / lock supervisor for one GTXE2_COMMON quad PLL.
// Sequences QPLLPD and QPLLRESET, qualifies QPLLLOCK through a
// consecutive-cycle filter, retries on timeout, fails over across the
// candidate reference clocks, and reports a clean pll_ready to the lanes.
module qpll_supervisor #(
    parameter int                         NUM_REFCLKS  = 2,
    parameter logic [3*NUM_REFCLKS-1:0]   REFCLK_CODES = {3'd2, 3'd1},
    parameter int                         PD_CYCLES    = 64,
    parameter int                         RESET_CYCLES = 32,
    parameter int                         LOCK_TIMEOUT = 125000,
    parameter int                         LOCK_FILTER  = 256,
    parameter int                         MAX_RETRIES  = 3
) (
    input  logic       clk_125mhz,
    input  logic       rst_n,
    input  logic [2:0] pref_idx,
    input  logic       force_reset,
    input  logic       qpll_lock,
    input  logic       qpll_refclk_lost,
    output logic       qpll_pd,
    output logic       qpll_reset,
    output logic [2:0] qpll_refclk_sel,
    output logic [2:0] active_idx,
    output logic       pll_ready,
    output logic       fault,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        PWRDN,
        RESET,
        WAIT_LOCK,
        LOCKED,
        SWITCH,
        FAULT
    } state_t;

    // One phase timer serves power-down, reset pulse and lock timeout.
    localparam int SEQ_MAX = (LOCK_TIMEOUT > PD_CYCLES)
                           ? ((LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES)
                           : ((PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES);
    localparam int TIMER_W = $clog2(SEQ_MAX + 1);
    localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int TRIED_W = $clog2(NUM_REFCLKS + 1);

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [FILT_W-1:0]    filter;
    logic [RETRY_W-1:0]   retries;
    logic [TRIED_W-1:0]   tried;
    logic                 lock_meta;
    logic                 lock_s;
    logic                 lost_meta;
    logic                 lost_s;
    logic                 started;
    logic [2:0]           idx_q;
    logic [2:0]           sel_q;
    logic [2:0]           pref_clamped;
    logic [2:0]           next_idx;
    logic [2:0]           code_tab [8];

    // Full 8-entry code table so any 3-bit index is in range; unused slots read 0.
    for (genvar g = 0; g < 8; g++) begin : g_codes
        if (g < NUM_REFCLKS) begin : g_used
            assign code_tab[g] = REFCLK_CODES[3*g +: 3];
        end else begin : g_unused
            assign code_tab[g] = 3'd0;
        end
    end

    assign pref_clamped = (int'(pref_idx) < NUM_REFCLKS) ? pref_idx : 3'd0;
    assign next_idx     = (int'(idx_q) >= NUM_REFCLKS - 1) ? 3'd0 : idx_q + 3'd1;

    // While rst_n is held the selection follows pref_idx so the PLL sees the
    // intended refclk from the start; the first edge after release captures it.
    assign active_idx      = started ? idx_q : pref_clamped;
    assign qpll_refclk_sel = started ? sel_q : code_tab[pref_clamped];

    // Lock synchroniser, held clear while the PLL is in reset since QPLLLOCK is meaningless then.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else if (qpll_reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= qpll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Two-flop synchroniser for the asynchronous refclk-lost flag.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            lost_meta <= 1'b0;
            lost_s    <= 1'b0;
        end else begin
            lost_meta <= qpll_refclk_lost;
            lost_s    <= lost_meta;
        end
    end

    // Supervisor sequence: power-down, reset pulse, lock qualification, retry and failover.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= PWRDN;
            timer           <= '0;
            filter          <= '0;
            retries         <= '0;
            tried           <= '0;
            started         <= 1'b0;
            idx_q           <= 3'd0;
            sel_q           <= 3'd0;
            qpll_pd         <= 1'b1;
            qpll_reset      <= 1'b1;
            pll_ready       <= 1'b0;
            fault           <= 1'b0;
            lock_loss_count <= 8'd0;
        end else if (force_reset) begin
            started    <= 1'b1;
            state      <= PWRDN;
            timer      <= '0;
            filter     <= '0;
            retries    <= '0;
            tried      <= '0;
            idx_q      <= pref_clamped;
            sel_q      <= code_tab[pref_clamped];
            qpll_pd    <= 1'b1;
            qpll_reset <= 1'b1;
            pll_ready  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            started <= 1'b1;
            if (!started) begin
                idx_q <= pref_clamped;
                sel_q <= code_tab[pref_clamped];
            end
            case (state)
                PWRDN: begin
                    qpll_pd    <= 1'b1;
                    qpll_reset <= 1'b1;
                    if (timer == TIMER_W'(PD_CYCLES - 1)) begin
                        qpll_pd <= 1'b0;
                        timer   <= '0;
                        state   <= RESET;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESET: begin
                    qpll_reset <= 1'b1;
                    if (timer == TIMER_W'(RESET_CYCLES - 1)) begin
                        qpll_reset <= 1'b0;
                        timer      <= '0;
                        filter     <= '0;
                        state      <= WAIT_LOCK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s && filter == FILT_W'(LOCK_FILTER - 1)) begin
                        filter  <= '0;
                        retries <= '0;
                        tried   <= '0;
                        state   <= LOCKED;
                    end else if (lost_s || timer == TIMER_W'(LOCK_TIMEOUT)) begin
                        timer      <= '0;
                        filter     <= '0;
                        qpll_reset <= 1'b1;
                        if (int'(retries) + 1 < MAX_RETRIES) begin
                            retries <= retries + 1'b1;
                            state   <= RESET;
                        end else begin
                            retries <= '0;
                            tried   <= tried + 1'b1;
                            if (int'(tried) + 1 >= NUM_REFCLKS) begin
                                fault <= 1'b1;
                                state <= FAULT;
                            end else begin
                                state <= SWITCH;
                            end
                        end
                    end else begin
                        timer  <= timer + 1'b1;
                        filter <= lock_s ? filter + 1'b1 : '0;
                    end
                end
                LOCKED: begin
                    if (!lock_s || lost_s) begin
                        pll_ready  <= 1'b0;
                        qpll_reset <= 1'b1;
                        timer      <= '0;
                        state      <= RESET;
                        if (lock_loss_count != 8'hFF) begin
                            lock_loss_count <= lock_loss_count + 8'd1;
                        end
                    end else begin
                        pll_ready <= 1'b1;
                    end
                end
                SWITCH: begin
                    qpll_reset <= 1'b1;
                    idx_q      <= next_idx;
                    sel_q      <= code_tab[next_idx];
                    timer      <= '0;
                    state      <= RESET;
                end
                FAULT: begin
                    fault      <= 1'b1;
                    qpll_reset <= 1'b1;
                    qpll_pd    <= 1'b0;
                    pll_ready  <= 1'b0;
                end
                default: begin
                    state <= PWRDN;
                end
            endcase
        end
    end

endmodule
